// File: rtl/processor_pkg.sv
// Shared opcode constants, flag bit positions and FSM state encoding for processor_pipe.
package processor_pkg;

    localparam int unsigned FLAGS_W = 4;

    localparam logic [7:0] OPC_ADD = 8'h01;
    localparam logic [7:0] OPC_SUB = 8'h02;
    localparam logic [7:0] OPC_AND = 8'h03;
    localparam logic [7:0] OPC_OR  = 8'h04;
    localparam logic [7:0] OPC_XOR = 8'h05;
    localparam logic [7:0] OPC_NOT = 8'h06;
    localparam logic [7:0] OPC_SHL = 8'h07;
    localparam logic [7:0] OPC_SHR = 8'h08;
    localparam logic [7:0] OPC_MUL = 8'h09;
    localparam logic [7:0] OPC_MOV = 8'h0D;

    localparam logic [1:0] FLAG_Z = 2'd0;
    localparam logic [1:0] FLAG_N = 2'd1;
    localparam logic [1:0] FLAG_C = 2'd2;
    localparam logic [1:0] FLAG_V = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/proc_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles after start_i.
// The final step is combinational so done_c_o and product_c_o are valid in the last busy cycle.
module proc_mul_seq #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     mcand_i,
    input  logic [DATA_W-1:0]     mplier_i,
    output logic                  done_c_o,
    output logic [2*DATA_W-1:0]   product_c_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [PROD_W-1:0] acc_q, mcand_q, acc_d;
    logic [DATA_W-1:0] mplier_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    assign acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_c_o    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign product_c_o = acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_c_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/processor_pipe.sv
// Single-issue ALU with IDLE/EXEC/HOLD handshake and registered result/flags.
// Optional iterative MUL (opcode 0x09) when PROC_MUL_EN is defined; otherwise 0x09 is illegal.
module processor_pipe
    import processor_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OPC_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [DATA_W-1:0]   operand1,
    input  logic [DATA_W-1:0]   operand2,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   result,
    output logic [FLAGS_W-1:0]  flags,
    output logic                ula_ready,
    output logic                op_err
);

    localparam int unsigned MSB = DATA_W - 1;

    state_e              state_q;
    logic [OPC_W-1:0]    opc_q;
    logic [DATA_W-1:0]   op1_q, op2_q, result_q, result_d;
    logic [FLAGS_W-1:0]  flags_q, flags_d;
    logic                ula_ready_q, op_err_q, op_err_d, in_ready_q;
    logic                carry_c, ovf_c, exec_wait_c;
    logic [DATA_W:0]     sum_c, diff_c;

    assign sum_c  = {1'b0, op1_q} + {1'b0, op2_q};
    assign diff_c = {1'b0, op1_q} - {1'b0, op2_q};

`ifdef PROC_MUL_EN
    logic                mul_start_c, mul_done_c;
    logic [2*DATA_W-1:0] mul_prod_c;

    assign mul_start_c = (state_q == ST_IDLE) && in_valid && (opcode == OPC_W'(OPC_MUL));
    assign exec_wait_c = (opc_q == OPC_W'(OPC_MUL)) && !mul_done_c;

    proc_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk         (clk),
        .reset       (reset),
        .start_i     (mul_start_c),
        .mcand_i     (operand1),
        .mplier_i    (operand2),
        .done_c_o    (mul_done_c),
        .product_c_o (mul_prod_c)
    );
`else
    assign exec_wait_c = 1'b0;
`endif

    // ALU decode/evaluate on the latched command
    always_comb begin
        result_d = '0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        op_err_d = 1'b0;
        case (opc_q)
            OPC_W'(OPC_ADD): begin
                result_d = sum_c[DATA_W-1:0];
                carry_c  = sum_c[DATA_W];
                ovf_c    = (op1_q[MSB] == op2_q[MSB]) && (result_d[MSB] != op1_q[MSB]);
            end
            OPC_W'(OPC_SUB): begin
                result_d = diff_c[DATA_W-1:0];
                carry_c  = diff_c[DATA_W];
                ovf_c    = (op1_q[MSB] != op2_q[MSB]) && (result_d[MSB] != op1_q[MSB]);
            end
            OPC_W'(OPC_AND): result_d = op1_q & op2_q;
            OPC_W'(OPC_OR):  result_d = op1_q | op2_q;
            OPC_W'(OPC_XOR): result_d = op1_q ^ op2_q;
            OPC_W'(OPC_NOT): result_d = ~op1_q;
            OPC_W'(OPC_SHL): begin
                result_d = op1_q << 1;
                carry_c  = op1_q[MSB];
            end
            OPC_W'(OPC_SHR): begin
                result_d = op1_q >> 1;
                carry_c  = op1_q[0];
            end
            OPC_W'(OPC_MOV): result_d = op1_q;
`ifdef PROC_MUL_EN
            OPC_W'(OPC_MUL): begin
                result_d = mul_prod_c[DATA_W-1:0];
                carry_c  = |mul_prod_c[2*DATA_W-1:DATA_W];
            end
`endif
            default: op_err_d = 1'b1;
        endcase

        flags_d = '0;
        if (!op_err_d) begin
            flags_d[FLAG_Z] = (result_d == '0);
            flags_d[FLAG_N] = result_d[MSB];
            flags_d[FLAG_C] = carry_c;
            flags_d[FLAG_V] = ovf_c;
        end
    end

    // Control FSM; result/flags/op_err only move on the edge that enters HOLD
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opc_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            op_err_q    <= 1'b0;
            ula_ready_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    opc_q      <= opcode;
                    op1_q      <= operand1;
                    op2_q      <= operand2;
                    in_ready_q <= 1'b0;
                    state_q    <= ST_EXEC;
                end
                ST_EXEC: if (!exec_wait_c) begin
                    result_q    <= result_d;
                    flags_q     <= flags_d;
                    op_err_q    <= op_err_d;
                    ula_ready_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: if (out_ready) begin
                    ula_ready_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    ula_ready_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign ula_ready = ula_ready_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_processor_pipe.sv
// Directed self-checking bench for processor_pipe (DATA_W=8); follows PROC_MUL_EN for MUL expectations.
module tb_processor_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;
    logic       ula_ready;
    logic       op_err;

    int checks = 0;
    int errors = 0;

    processor_pipe #(.DATA_W(8), .OPC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .ula_ready (ula_ready),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command, measure accept-to-ula_ready latency, check outputs, then release.
    task automatic run_op(input string tag, input logic [7:0] opc, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res,
                          input logic [3:0] exp_flags, input logic exp_err, input int exp_lat);
        int lat;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b1; opcode = opc; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " early_valid"}, 32'(ula_ready), 32'd0);
        lat = 0;
        while (!ula_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " flags"}, 32'(flags), 32'(exp_flags));
        check({tag, " op_err"}, 32'(op_err), 32'(exp_err));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " release"}, 32'(ula_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seen;
        reset = 1'b1; in_valid = 1'b0; opcode = '0; operand1 = '0; operand2 = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst result", 32'(result), 32'd0);
        check("rst flags", 32'(flags), 32'd0);
        check("rst ula_ready", 32'(ula_ready), 32'd0);
        check("rst op_err", 32'(op_err), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add_wrap", 8'h01, 8'hFF, 8'h01, 8'h00, 4'h5, 1'b0, 1);
        run_op("sub_borrow", 8'h02, 8'h05, 8'h07, 8'hFE, 4'h6, 1'b0, 1);
        run_op("add_ovf", 8'h01, 8'h7F, 8'h01, 8'h80, 4'hA, 1'b0, 1);
        run_op("mov", 8'h0D, 8'hA5, 8'h00, 8'hA5, 4'h2, 1'b0, 1);
        run_op("illegal", 8'h3C, 8'h12, 8'h34, 8'h00, 4'h0, 1'b1, 1);
        run_op("and", 8'h03, 8'hF0, 8'h3C, 8'h30, 4'h0, 1'b0, 1);
        run_op("or", 8'h04, 8'h0F, 8'hF0, 8'hFF, 4'h2, 1'b0, 1);
        run_op("xor", 8'h05, 8'hAA, 8'hAA, 8'h00, 4'h1, 1'b0, 1);
        run_op("not", 8'h06, 8'h0F, 8'h99, 8'hF0, 4'h2, 1'b0, 1);
        run_op("shl", 8'h07, 8'h81, 8'h00, 8'h02, 4'h4, 1'b0, 1);
        run_op("shr", 8'h08, 8'h01, 8'h00, 8'h00, 4'h5, 1'b0, 1);
`ifdef PROC_MUL_EN
        run_op("mul", 8'h09, 8'h10, 8'h20, 8'h00, 4'h5, 1'b0, 8);
        run_op("mul_small", 8'h09, 8'h07, 8'h06, 8'h2A, 4'h0, 1'b0, 8);
`else
        run_op("mul_off", 8'h09, 8'h10, 8'h20, 8'h00, 4'h0, 1'b1, 1);
`endif

        // Backpressure: hold for 3 cycles while a second command is offered
        @(negedge clk);
        in_valid = 1'b1; opcode = 8'h01; operand1 = 8'h10; operand2 = 8'h20;
        @(posedge clk); #1;
        opcode = 8'h02; operand1 = 8'h55; operand2 = 8'h11;
        @(posedge clk); #1;
        check("hold entry", 32'(ula_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold result", 32'(result), 32'h30);
            check("hold valid", 32'(ula_ready), 32'd1);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold release valid", 32'(ula_ready), 32'd0);
        check("hold release in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("no stray accept", 32'(in_ready), 32'd1);
        check("hold result kept", 32'(result), 32'h30);

        // Reset in EXEC discards the operation
        @(negedge clk);
        in_valid = 1'b1; opcode = 8'h09; operand1 = 8'h10; operand2 = 8'h20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_exec in_ready", 32'(in_ready), 32'd1);
        check("rst_exec result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ula_ready) seen++;
        end
        check("rst_exec no valid", 32'(seen), 32'd0);
        run_op("post_rst add", 8'h01, 8'h10, 8'h20, 8'h30, 4'h0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
